cal_nth_weekday: RTL and testbench

CAL_NTH_WEEKDAY -- requirements
Module: cal_nth_weekday

---
 rtl/cal_nth_weekday.sv | 222 ++++++++++++++++++++++
 tb/tb_cal_nth_weekday.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cal_nth_weekday.sv
// cal_nth_weekday: resolves the day of month of the nth occurrence of a
// weekday in a given (year, month). It walks forward from 1 Jan BASE_YEAR
// one year per cycle, then one month per cycle, tracking the weekday of the
// 1st. It then converts that weekday into the requested day of month.
module cal_nth_weekday #(
    parameter int unsigned BASE_YEAR = 1755,
    parameter int unsigned LAST_YEAR = 2033,
    parameter int unsigned BASE_DOW  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] year,
    input  logic [3:0]  month,
    input  logic [2:0]  dayOfWeek,
    input  logic [2:0]  nth,
    output logic        busy,
    output logic        done,
    output logic [4:0]  day,
    output logic        errorFlag
);

    localparam int unsigned YW = 16;
    localparam int unsigned MW = 4;
    localparam int unsigned WW = 3;
    localparam int unsigned NW = 3;
    localparam int unsigned DW = 5;
    localparam int unsigned SW = 6;

    localparam logic [YW-1:0] BASE_Y = YW'(BASE_YEAR);
    localparam logic [YW-1:0] LAST_Y = YW'(LAST_YEAR);
    localparam logic [WW-1:0] BASE_W = WW'(BASE_DOW);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        YEARS   = 2'd1,
        MONTHS  = 2'd2,
        RESOLVE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [YW-1:0]  y_q, y_d;
    logic [MW-1:0]  m_q, m_d;
    logic [WW-1:0]  w_q, w_d;
    logic [YW-1:0]  year_q, year_d;
    logic [MW-1:0]  month_q, month_d;
    logic [WW-1:0]  dow_q, dow_d;
    logic [NW-1:0]  nth_q, nth_d;
    logic           err_q, err_d;
    logic           hold_q, hold_d;
    logic           busy_d, done_d, error_d;
    logic [DW-1:0]  day_d;

    // Gregorian leap-year rule
    function automatic logic is_leap(input logic [YW-1:0] yr);
        logic div4, div100, div400;
        div4   = ((yr % YW'(4))   == '0);
        div100 = ((yr % YW'(100)) == '0);
        div400 = ((yr % YW'(400)) == '0);
        return (div4 && !div100) || div400;
    endfunction

    // Days in month; out-of-range months only occur on the error path
    function automatic logic [DW-1:0] days_in(input logic [MW-1:0] mo, input logic lp);
        logic [DW-1:0] r;
        case (mo)
            4'd2:                      r = lp ? DW'(29) : DW'(28);
            4'd4, 4'd6, 4'd9, 4'd11:   r = DW'(30);
            default:                   r = DW'(31);
        endcase
        return r;
    endfunction

    // Reduce a value in 0..13 modulo 7
    function automatic logic [WW-1:0] wrap7(input logic [3:0] v);
        return (v >= 4'd7) ? WW'(v - 4'd7) : WW'(v);
    endfunction

    logic           year_leap_c;
    logic           y_leap_c;
    logic [DW-1:0]  m_dim_c;
    logic [DW-1:0]  target_dim_c;
    logic [WW-1:0]  first_off_c;
    logic [SW-1:0]  first_c;
    logic [SW-1:0]  cand_c;
    logic           range_bad_c;

    // Datapath helpers shared by the walk and resolve steps
    always_comb begin
        year_leap_c  = is_leap(year_q);
        y_leap_c     = is_leap(y_q);
        m_dim_c      = days_in(m_q, year_leap_c);
        target_dim_c = days_in(month_q, year_leap_c);
        first_off_c  = wrap7(4'(dow_q) + 4'd7 - 4'(w_q));
        first_c      = SW'(first_off_c) + SW'(1);
        cand_c       = first_c + SW'(7) * SW'(nth_q - NW'(1));
        range_bad_c  = (year < BASE_Y) || (year > LAST_Y) ||
                       (month == '0) || (month > MW'(12)) ||
                       (dayOfWeek == WW'(7)) ||
                       (nth == '0) || (nth > NW'(5));
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        m_d     = m_q;
        w_d     = w_q;
        year_d  = year_q;
        month_d = month_q;
        dow_d   = dow_q;
        nth_d   = nth_q;
        err_d   = err_q;
        hold_d  = hold_q;
        busy_d  = busy;
        done_d  = 1'b0;
        day_d   = day;
        error_d = errorFlag;

        case (state_q)
            IDLE: begin
                if (start) begin
                    year_d  = year;
                    month_d = month;
                    dow_d   = dayOfWeek;
                    nth_d   = nth;
                    busy_d  = 1'b1;
                    if (range_bad_c) begin
                        // Error path holds one extra cycle in RESOLVE so
                        // rejected requests complete two cycles after acceptance
                        state_d = RESOLVE;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end else begin
                        state_d = YEARS;
                        err_d   = 1'b0;
                        hold_d  = 1'b0;
                        y_d     = BASE_Y;
                        w_d     = BASE_W;
                    end
                end
            end

            YEARS: begin
                if (y_q == year_q) begin
                    state_d = MONTHS;
                    m_d     = MW'(1);
                end else begin
                    w_d = wrap7(4'(w_q) + 4'd1 + 4'(y_leap_c));
                    y_d = y_q + YW'(1);
                end
            end

            MONTHS: begin
                if (m_q == month_q) begin
                    state_d = RESOLVE;
                end else begin
                    // dim mod 7 equals dim - 28 for every month length
                    w_d = wrap7(4'(w_q) + 4'(m_dim_c - DW'(28)));
                    m_d = m_q + MW'(1);
                end
            end

            RESOLVE: begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (err_q || (cand_c > SW'(target_dim_c))) begin
                        day_d   = '0;
                        error_d = 1'b1;
                    end else begin
                        day_d   = DW'(cand_c);
                        error_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            y_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            year_q    <= '0;
            month_q   <= '0;
            dow_q     <= '0;
            nth_q     <= '0;
            err_q     <= 1'b0;
            hold_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            day       <= '0;
            errorFlag <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            m_q       <= m_d;
            w_q       <= w_d;
            year_q    <= year_d;
            month_q   <= month_d;
            dow_q     <= dow_d;
            nth_q     <= nth_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
            busy      <= busy_d;
            done      <= done_d;
            day       <= day_d;
            errorFlag <= error_d;
        end
    end

endmodule

// File: tb/tb_cal_nth_weekday.sv
// Bench for cal_nth_weekday: directed scenarios plus random requests checked
// against a calendar model built on Sakamoto's day-of-week formula.
module tb_cal_nth_weekday;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] year;
    logic [3:0]  month;
    logic [2:0]  dayOfWeek;
    logic [2:0]  nth;
    logic        busy;
    logic        done;
    logic [4:0]  day;
    logic        errorFlag;

    int checks = 0;
    int errors = 0;

    cal_nth_weekday dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .year      (year),
        .month     (month),
        .dayOfWeek (dayOfWeek),
        .nth       (nth),
        .busy      (busy),
        .done      (done),
        .day       (day),
        .errorFlag (errorFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_leap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0) ? 1 : 0;
    endfunction

    function automatic int ref_dim(input int y, input int m);
        int t[12];
        t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        return t[m-1] + ((m == 2) ? ref_leap(y) : 0);
    endfunction

    // Sakamoto: weekday of a date, 0 = Sunday
    function automatic int ref_dow(input int y, input int m, input int d);
        int t[12];
        int yy;
        t  = '{0, 3, 2, 5, 0, 3, 5, 1, 4, 6, 2, 4};
        yy = (m < 3) ? y - 1 : y;
        return (yy + yy / 4 - yy / 100 + yy / 400 + t[m-1] + d) % 7;
    endfunction

    // Scan the month day by day counting matching weekdays
    task automatic ref_model(input int y, input int m, input int dw, input int n,
                             output int exp_day, output int exp_err, output int exp_lat);
        int cnt;
        exp_day = 0;
        exp_err = 1;
        exp_lat = 2;
        if (y < 1755 || y > 2033 || m < 1 || m > 12 || dw > 6 || n < 1 || n > 5) return;
        exp_lat = (y - 1755) + m + 2;
        cnt = 0;
        for (int d = 1; d <= ref_dim(y, m); d++) begin
            if (ref_dow(y, m, d) == dw) begin
                cnt++;
                if (cnt == n) begin
                    exp_day = d;
                    exp_err = 0;
                end
            end
        end
    endtask

    // Issue one request from a post-edge sampling point and follow it to done
    task automatic run_req(input string tag, input int y, input int m, input int dw,
                           input int n, input bit disturb);
        int exp_day, exp_err, exp_lat, cyc;
        bit seen;
        logic [4:0] prev_day;
        logic prev_err;
        ref_model(y, m, dw, n, exp_day, exp_err, exp_lat);
        prev_day  = day;
        prev_err  = errorFlag;
        year      = 16'(y);
        month     = 4'(m);
        dayOfWeek = 3'(dw);
        nth       = 3'(n);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_accept"}, 32'(busy), 32'd1);
        check({tag, "_done_low_accept"}, 32'(done), 32'd0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (disturb && cyc == 4) begin
                start     = 1'b1;
                year      = 16'd1800;
                month     = 4'd3;
                dayOfWeek = 3'd1;
                nth       = 3'd1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                check({tag, "_busy_hold"}, 32'(busy), 32'd1);
                check({tag, "_day_hold"}, 32'(day), 32'(prev_day));
                check({tag, "_err_hold"}, 32'(errorFlag), 32'(prev_err));
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_day"}, 32'(day), 32'(exp_day));
        check({tag, "_err"}, 32'(errorFlag), 32'(exp_err));
        check({tag, "_busy_clear"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ry, rm, rdw, rn, sel;
        rst_n     = 1'b0;
        start     = 1'b0;
        year      = '0;
        month     = '0;
        dayOfWeek = '0;
        nth       = '0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_day", 32'(day), 32'd0);
        check("reset_err", 32'(errorFlag), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios; consecutive calls also exercise start during done
        run_req("base",     1755, 1, 0, 1, 1'b0);
        check("base_day_const", 32'(day), 32'd5);
        run_req("mid",      2014, 10, 5, 3, 1'b0);
        check("mid_day_const", 32'(day), 32'd17);
        run_req("leap2000", 2000, 2, 2, 5, 1'b0);
        check("leap_day_const", 32'(day), 32'd29);
        run_req("cent1900", 1900, 2, 4, 5, 1'b0);
        check("cent_err_const", 32'(errorFlag), 32'd1);
        run_req("yr2034",   2034, 6, 1, 1, 1'b0);
        run_req("mon13",    2000, 13, 1, 1, 1'b0);
        run_req("nth0",     2000, 5, 1, 0, 1'b0);
        run_req("dow7",     2000, 5, 7, 1, 1'b0);
        run_req("yr1754",   1754, 5, 1, 1, 1'b0);
        run_req("last",     2033, 12, 6, 5, 1'b0);
        run_req("busyhit",  2014, 10, 5, 3, 1'b1);
        check("busyhit_day_const", 32'(day), 32'd17);

        // Reset while walking years
        year      = 16'd2014;
        month     = 4'd10;
        dayOfWeek = 3'd5;
        nth       = 3'd3;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_day", 32'(day), 32'd0);
        check("midrst_err", 32'(errorFlag), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_no_done", 32'(done), 32'd0);
        run_req("postrst", 2014, 10, 5, 3, 1'b0);

        // Random requests, mostly valid with occasional range violations
        for (int i = 0; i < 25; i++) begin
            ry  = int'($urandom_range(1755, 2033));
            rm  = int'($urandom_range(1, 12));
            rdw = int'($urandom_range(0, 6));
            rn  = int'($urandom_range(1, 5));
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: ry  = int'($urandom_range(2034, 2100));
                1: rm  = (i % 2 == 0) ? 0 : int'($urandom_range(13, 15));
                2: rn  = (i % 2 == 0) ? 0 : int'($urandom_range(6, 7));
                default: ;
            endcase
            run_req("rand", ry, rm, rdw, rn, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
